// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Sequential signed multiplier / divider for the multicycle MIPS datapath.
//   Multiply: radix-2 Booth over {A,Q,q-1}. Divide: restoring division on
//   operand magnitudes followed by a sign fix-up. One setup cycle, ITERS
//   iteration cycles, then a single FINISH cycle carrying done.
//
//   Optional feature macro: MULT_DIV_UNSIGNED_EN adds the unsigned_op input
//   (MULTU/DIVU when high). Without it every operation is signed.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-low reset
//   start_mult  in   signed multiply request (IDLE only)
//   start_div   in   signed divide request (IDLE only, multiply wins a tie)
//   unsigned_op in   (MULT_DIV_UNSIGNED_EN only) unsigned operation select
//   a, b        in   operands, latched on the accepting edge
//   busy        out  operation in progress
//   done        out  one-cycle pulse, hi/lo valid
//   div_zero    out  one-cycle pulse with done for a divide by zero
//   hi, lo      out  product upper/lower word, or remainder/quotient
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, FINISH} state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    counter_r;
  logic             setup_r;     // first cycle after accept: operand preparation
  logic             dz_r;        // divisor was zero
  logic [WIDTH-1:0] hi_acc_r;    // Booth A / division remainder R
  logic [WIDTH-1:0] lo_acc_r;    // Booth Q / dividend-quotient Q
  logic             qm1_r;       // Booth q-1
  logic [WIDTH-1:0] mag_r;       // multiplicand M / divisor magnitude
  logic             neg_q_r;
  logic             neg_r_r;
  logic             busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             uns_s;
  logic [WIDTH-1:0] corr_s;

  // Two's-complement magnitude; the most negative value maps to itself,
  // which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) return {WIDTH{1'b0}} - v;
    else            return v;
  endfunction

`ifdef MULT_DIV_UNSIGNED_EN
  logic             uns_r;
  logic [WIDTH-1:0] braw_r;      // raw multiplier, needed for the unsigned hi correction
  assign uns_s = uns_r;

  // Unsigned product = signed product + 2^W*(a31*b + b31*a); only hi changes.
  always_comb begin
    corr_s = {WIDTH{1'b0}};
    if (uns_s) begin
      if (mag_r[WIDTH-1])  corr_s = corr_s + braw_r;
      else                 corr_s = corr_s;
      if (braw_r[WIDTH-1]) corr_s = corr_s + mag_r;
      else                 corr_s = corr_s;
    end else begin
      corr_s = {WIDTH{1'b0}};
    end
  end
`else
  assign uns_s  = 1'b0;
  assign corr_s = {WIDTH{1'b0}};
`endif

  logic last_step_s;
  assign last_step_s = !setup_r && (counter_r == ONE_C);

  // Booth step: A +/- M evaluated one bit wider so M = -2^(W-1) cannot overflow.
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH-1:0] booth_hi_s, booth_lo_s;
  always_comb begin
    booth_sum_s = {hi_acc_r[WIDTH-1], hi_acc_r};
    case ({lo_acc_r[0], qm1_r})
      2'b01:   booth_sum_s = {hi_acc_r[WIDTH-1], hi_acc_r} + {mag_r[WIDTH-1], mag_r};
      2'b10:   booth_sum_s = {hi_acc_r[WIDTH-1], hi_acc_r} - {mag_r[WIDTH-1], mag_r};
      default: booth_sum_s = {hi_acc_r[WIDTH-1], hi_acc_r};
    endcase
    booth_hi_s = booth_sum_s[WIDTH:1];
    booth_lo_s = {booth_sum_s[0], lo_acc_r[WIDTH-1:1]};
  end

  // Restoring division step. R < |b| before the shift, so the kept remainder
  // always fits WIDTH bits and the low WIDTH bits of the difference suffice.
  logic [WIDTH:0]   r_sh_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] div_hi_s, div_lo_s;
  always_comb begin
    r_sh_s   = {hi_acc_r, lo_acc_r[WIDTH-1]};
    q_bit_s  = (r_sh_s >= {1'b0, mag_r});
    if (q_bit_s) div_hi_s = r_sh_s[WIDTH-1:0] - mag_r;
    else         div_hi_s = r_sh_s[WIDTH-1:0];
    div_lo_s = {lo_acc_r[WIDTH-2:0], q_bit_s};
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_mult)     state_s = MULT_RUN;
        else if (start_div) state_s = DIV_RUN;
        else                state_s = IDLE;
      end
      MULT_RUN: begin
        if (last_step_s) state_s = FINISH;
        else             state_s = MULT_RUN;
      end
      DIV_RUN: begin
        if (!setup_r && (dz_r || last_step_s)) state_s = FINISH;
        else                                   state_s = DIV_RUN;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath, iteration counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      counter_r  <= {CW{1'b0}};
      setup_r    <= 1'b0;
      dz_r       <= 1'b0;
      hi_acc_r   <= {WIDTH{1'b0}};
      lo_acc_r   <= {WIDTH{1'b0}};
      qm1_r      <= 1'b0;
      mag_r      <= {WIDTH{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
`ifdef MULT_DIV_UNSIGNED_EN
      uns_r      <= 1'b0;
      braw_r     <= {WIDTH{1'b0}};
`endif
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_mult || start_div) begin
            busy_r    <= 1'b1;
            counter_r <= ITERS_C;
            setup_r   <= 1'b1;
            dz_r      <= 1'b0;
            hi_acc_r  <= {WIDTH{1'b0}};
            qm1_r     <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            if (start_mult) begin
              lo_acc_r <= b;
              mag_r    <= a;
            end else begin
              lo_acc_r <= a;
              mag_r    <= b;
            end
`ifdef MULT_DIV_UNSIGNED_EN
            uns_r  <= unsigned_op;
            braw_r <= b;
`endif
          end
        end
        MULT_RUN: begin
          if (setup_r) begin
            setup_r <= 1'b0;
          end else begin
            hi_acc_r  <= booth_hi_s;
            lo_acc_r  <= booth_lo_s;
            qm1_r     <= lo_acc_r[0];
            counter_r <= counter_r - ONE_C;
            if (last_step_s) begin
              hi_r   <= booth_hi_s + corr_s;
              lo_r   <= booth_lo_s;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          if (setup_r) begin
            setup_r <= 1'b0;
            dz_r    <= (mag_r == {WIDTH{1'b0}});
            if (!uns_s) begin
              neg_q_r  <= lo_acc_r[WIDTH-1] ^ mag_r[WIDTH-1];
              neg_r_r  <= lo_acc_r[WIDTH-1];
              lo_acc_r <= abs_val(lo_acc_r);
              mag_r    <= abs_val(mag_r);
            end
          end else if (dz_r) begin
            // hi/lo deliberately left untouched
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            div_zero_r <= 1'b1;
          end else begin
            hi_acc_r  <= div_hi_s;
            lo_acc_r  <= div_lo_s;
            counter_r <= counter_r - ONE_C;
            if (last_step_s) begin
              lo_r   <= neg_q_r ? ({WIDTH{1'b0}} - div_lo_s) : div_lo_s;
              hi_r   <= neg_r_r ? ({WIDTH{1'b0}} - div_hi_s) : div_hi_s;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        FINISH: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule
